// File: rtl/stub_pkg.sv
// Shared constants for the stub collector: register map, FSM encodings, defaults.
package stub_pkg;

  localparam int unsigned NLAYERS_DEF = 6;
  localparam int unsigned DW_DEF      = 8;

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_DROP    = 2'd3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    COLLECT = ST_COLLECT,
    FLUSH   = ST_FLUSH
  } state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/stub_cfg_regs.sv
// Configuration register file with registered read port and saturating drop counter.
module stub_cfg_regs
  import stub_pkg::*;
#(
  parameter int unsigned NLAYERS = NLAYERS_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mem_en,
  input  logic               mem_rd_wr,
  input  logic [1:0]         mem_add,
  input  logic [7:0]         mem_data,
  output logic [7:0]         mem_rdata,
  input  logic [3:0]         drops,
  output logic [NLAYERS-1:0] en_mask,
  output logic [7:0]         timeout,
  output logic               partial_en
);

  logic [7:0] drop_cnt;
  logic [7:0] rd_val;
  logic [8:0] drop_sum;
  logic       wr;
  logic       clear_drop;

  assign wr         = mem_en && mem_rd_wr;
  assign clear_drop = wr && (mem_add == ADDR_CTRL) && mem_data[1];
  assign drop_sum   = {1'b0, drop_cnt} + {5'b00000, drops};

  always_comb begin
    rd_val = '0;
    case (mem_add)
      ADDR_MASK:    rd_val = 8'(en_mask);
      ADDR_TIMEOUT: rd_val = timeout;
      ADDR_CTRL:    rd_val = {7'b0000000, partial_en};
      default:      rd_val = drop_cnt;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      en_mask    <= '1;
      timeout    <= '0;
      partial_en <= 1'b0;
      drop_cnt   <= '0;
      mem_rdata  <= '0;
    end else begin
      if (wr && mem_add == ADDR_MASK)    en_mask    <= mem_data[NLAYERS-1:0];
      if (wr && mem_add == ADDR_TIMEOUT) timeout    <= mem_data;
      if (wr && mem_add == ADDR_CTRL)    partial_en <= mem_data[0];
      if (mem_en && !mem_rd_wr)          mem_rdata  <= rd_val;
      // clearing takes priority over any increment landing in the same cycle
      if (clear_drop)       drop_cnt <= '0;
      else if (drop_sum[8]) drop_cnt <= '1;
      else                  drop_cnt <= drop_sum[7:0];
    end
  end

endmodule

// File: rtl/stub_collector.sv
// Collects per-layer stubs into one candidate; completes on full mask or timeout.
module stub_collector
  import stub_pkg::*;
#(
  parameter int unsigned NLAYERS = NLAYERS_DEF,
  parameter int unsigned DW      = DW_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NLAYERS-1:0]        data_valid,
  input  logic [NLAYERS*DW-1:0]     data_in_x,
  input  logic [NLAYERS*DW-1:0]     data_in_y,
  input  logic [NLAYERS*DW-1:0]     data_in_z,
  input  logic                      mem_en,
  input  logic                      mem_rd_wr,
  input  logic [1:0]                mem_add,
  input  logic [7:0]                mem_data,
  output logic [7:0]                mem_rdata,
  output logic [NLAYERS*3*DW-1:0]   data_out,
  output logic [NLAYERS-1:0]        hit_mask,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [1:0]              state, state_n;
  logic [NLAYERS-1:0]      en_mask, en_lat, en_lat_n, eff_mask, vmask;
  logic [NLAYERS-1:0]      held, held_n, cap, cand;
  logic [NLAYERS*3*DW-1:0] buffer, buffer_n;
  logic [7:0]              timeout, timer, timer_n;
  logic                    partial_en, out_free, done, load;
  logic [3:0]              drops;

  stub_cfg_regs #(.NLAYERS(NLAYERS)) u_cfg (
    .clock      (clock),
    .reset      (reset),
    .mem_en     (mem_en),
    .mem_rd_wr  (mem_rd_wr),
    .mem_add    (mem_add),
    .mem_data   (mem_data),
    .mem_rdata  (mem_rdata),
    .drops      (drops),
    .en_mask    (en_mask),
    .timeout    (timeout),
    .partial_en (partial_en)
  );

  assign out_free = !out_valid || out_ready;
  assign eff_mask = (state == ST_IDLE) ? en_mask : en_lat;
  assign vmask    = data_valid & eff_mask;

  always_comb begin
    state_n  = state;
    en_lat_n = en_lat;
    held_n   = held;
    buffer_n = buffer;
    timer_n  = timer;
    cap      = '0;
    cand     = '0;
    drops    = '0;
    done     = 1'b0;
    load     = 1'b0;
    case (state)
      ST_IDLE, ST_COLLECT: begin
        if (state == ST_IDLE) begin
          en_lat_n = en_mask;
          if (|vmask) begin
            timer_n = timeout;
            state_n = ST_COLLECT;
          end
        end
        cap    = vmask & ~held;
        drops  = popcount8(8'(vmask & held));
        held_n = held | cap;
        for (int unsigned i = 0; i < NLAYERS; i++)
          if (cap[i])
            buffer_n[i*3*DW +: 3*DW] = {data_in_z[i*DW +: DW], data_in_y[i*DW +: DW],
                                        data_in_x[i*DW +: DW]};
        if (|held_n && held_n == eff_mask) begin
          done = 1'b1;
        end else if (state == ST_COLLECT && timeout != 8'd0) begin
          if (timer <= 8'd1) begin
            if (partial_en) begin
              done = 1'b1;
            end else begin
              drops   = drops + 4'd1;
              held_n  = '0;
              state_n = ST_IDLE;
            end
          end else begin
            timer_n = timer - 8'd1;
          end
        end
      end
      ST_FLUSH: begin
        drops = popcount8(8'(vmask));
        if (out_free) begin
          load    = 1'b1;
          cand    = held;
          held_n  = '0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (done) begin
      cand = held_n;
      if (out_free) begin
        load    = 1'b1;
        held_n  = '0;
        state_n = ST_IDLE;
      end else begin
        state_n = ST_FLUSH;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      en_lat    <= '1;
      held      <= '0;
      buffer    <= '0;
      timer     <= '0;
      out_valid <= 1'b0;
      hit_mask  <= '0;
      data_out  <= '0;
    end else begin
      state  <= state_n;
      en_lat <= en_lat_n;
      held   <= held_n;
      buffer <= buffer_n;
      timer  <= timer_n;
      if (load) begin
        out_valid <= 1'b1;
        hit_mask  <= cand;
        data_out  <= buffer_n;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
